serial_subtractor: RTL and testbench

//   Multi-cycle digit-serial subtractor: out = in1 - in2, processed DIGIT bits per clock, LSB first.

---
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial out = in1 - in2, DIGIT bits per clock, LSB first,
// with start/busy/done handshake and borrow/overflow/zero/negative flags.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a, b, acc, acc_next;
    logic [CW-1:0]    cnt;
    logic             carry, msb1, msb2, accept, last;
    logic [DIGIT:0]   sum;

    assign accept = start && state != RUN;
    assign last   = cnt == CW'(N - 1);
    assign busy   = state == RUN;
    assign done   = state == DONE;

    // subtract as A + ~B + 1: the +1 enters as the initial carry
    assign sum      = {1'b0, a[DIGIT-1:0]} + {1'b0, ~b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign acc_next = WIDTH'({sum[DIGIT-1:0], acc} >> DIGIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            msb1     <= 1'b0;
            msb2     <= 1'b0;
            out      <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (accept) begin
            a     <= in1;
            b     <= in2;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b1;
            msb1  <= in1[WIDTH-1];
            msb2  <= in2[WIDTH-1];
        end else if (state == RUN) begin
            a     <= a >> DIGIT;
            b     <= b >> DIGIT;
            acc   <= acc_next;
            carry <= sum[DIGIT];
            cnt   <= cnt + 1'b1;
            if (last) begin
                out      <= acc_next;
                borrow   <= ~sum[DIGIT];
                overflow <= (msb1 != msb2) && (acc_next[WIDTH-1] != msb1);
                zero     <= acc_next == '0;
                negative <= acc_next[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with hand-computed results for serial_subtractor.
module tb_serial_subtractor;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] in1 = '0, in2 = '0, out;
    logic        busy, done, borrow, overflow, zero, negative;
    int          total = 0, bad = 0, lat, bc;

    serial_subtractor dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .out(out), .borrow(borrow),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags packed as {borrow, overflow, zero, negative}
    function automatic logic [3:0] flags();
        return {borrow, overflow, zero, negative};
    endfunction

    // wait for done from just after an accepting edge; lat = edges until done
    task automatic wait_done();
        lat = 0;
        bc  = 0;
        while (!done && lat < 30) begin
            if (busy) bc++;
            @(posedge clk);
            #1 lat++;
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y);
        in1   = x;
        in2   = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in1 = ~x;
        in2 = ~y;
        wait_done();
        chk("latency", lat, 8);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("rst_out", out, 0);
        chk("rst_flags", flags(), 4'b0000);
        chk("rst_busy_done", {busy, done}, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op(32'd5, 32'd3);
        chk("t1_out", out, 32'd2);
        chk("t1_flags", flags(), 4'b0000);

        op(32'd0, 32'd1);
        chk("t2_out", out, 32'hFFFF_FFFF);
        chk("t2_flags", flags(), 4'b1001);

        op(32'h8000_0000, 32'd1);
        chk("t3a_out", out, 32'h7FFF_FFFF);
        chk("t3a_flags", flags(), 4'b0100);

        op(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        chk("t3b_out", out, 32'h8000_0000);
        chk("t3b_flags", flags(), 4'b1101);

        op(32'h1234_ABCD, 32'h1234_ABCD);
        chk("t4_out", out, 0);
        chk("t4_flags", flags(), 4'b0010);
        chk("t4_busy_cycles", bc, 8);
        @(posedge clk);
        #1 chk("t4_done_one_cycle", done, 1'b0);
        chk("t4_hold_out", out, 0);

        // start while busy must be ignored
        in1   = 32'd10;
        in2   = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 in1 = 32'd9;
        in2   = 32'd9;
        start = 1'b1;
        chk("t5_hold_in_run", out, 0);
        chk("t5_busy", busy, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        chk("t5_latency", lat, 5);
        chk("t5_out", out, 32'd6);
        // start held through DONE: accepted immediately
        in1   = 32'd20;
        in2   = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t5_rerun_busy", busy, 1'b1);
        wait_done();
        chk("t5_b2b_period", lat + 1, 9);
        chk("t5b_out", out, 32'd15);

        // async reset mid-run
        @(posedge clk);
        #1 in1 = 32'd100;
        in2   = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("t6_rst_out", out, 0);
        chk("t6_rst_bd", {busy, done}, 2'b00);
        chk("t6_rst_flags", flags(), 4'b0000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        op(32'd7, 32'd2);
        chk("t6_out", out, 32'd5);
        chk("t6_flags", flags(), 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
